// File: rtl/ay_env_multi_if.sv
// Write-port bundle for ay_env_multi: register writes from the sound-core
// register file into the per-channel envelope shape/period registers.
interface ay_env_multi_if #(
  parameter int NUM_CH   = 3,
  parameter int PERIOD_W = 16
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  // Handshake: strobe-only, with no ready. A write is taken on every rising
  // clk edge where wr_en is high. wr_ch, wr_is_shape and wr_data only matter
  // in that cycle. Writes to wr_ch >= NUM_CH are dropped silently.
  logic                wr_en;
  logic [CH_W-1:0]     wr_ch;
  logic                wr_is_shape;
  logic [PERIOD_W-1:0] wr_data;

  modport master (output wr_en, output wr_ch, output wr_is_shape, output wr_data);
  modport slave  (input  wr_en, input  wr_ch, input  wr_is_shape, input  wr_data);
endinterface

// File: rtl/ay_env_multi.sv
// ay_env_multi: NUM_CH independent AY/YM envelope generators. Each channel
// supports all 16 shapes and has its own shape and period register.
// Optional feature macro AY_ENV_DONE_EN adds env_done: a one-cycle pulse on
// the edge where a channel enters its held state.
module ay_env_multi #(
  parameter int NUM_CH   = 3,
  parameter int AMP_W    = 4,
  parameter int PERIOD_W = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    env_clk_tick,
  ay_env_multi_if.slave           wr_bus,
  output logic [NUM_CH*AMP_W-1:0] out
`ifdef AY_ENV_DONE_EN
  ,
  output logic [NUM_CH-1:0]       env_done
`endif
);

  localparam logic [AMP_W-1:0] MAX = '1;

  // Per-channel state, registered (_q) and next (_n)
  logic [3:0]          shape_q    [NUM_CH];
  logic [3:0]          shape_n    [NUM_CH];
  logic [PERIOD_W-1:0] period_q   [NUM_CH];
  logic [PERIOD_W-1:0] period_n   [NUM_CH];
  logic [PERIOD_W-1:0] ctr_q      [NUM_CH];
  logic [PERIOD_W-1:0] ctr_n      [NUM_CH];
  logic [AMP_W-1:0]    step_q     [NUM_CH];
  logic [AMP_W-1:0]    step_n     [NUM_CH];
  logic [AMP_W-1:0]    hold_val_q [NUM_CH];
  logic [AMP_W-1:0]    hold_val_n [NUM_CH];
  logic [NUM_CH-1:0]   dir_q, dir_n;
  logic [NUM_CH-1:0]   held_q, held_n;
  logic [NUM_CH*AMP_W-1:0] out_n;

  // Next-state per channel: a shape write restarts the channel and beats any
  // coincident tick. A tick compares against the period before any same-cycle
  // period write. Out is derived from the next state, so it changes on the
  // same edge as the state it shows.
  always_comb begin
    logic              sel_shape;
    logic              sel_period;
    logic [PERIOD_W:0] eff;
    logic [PERIOD_W:0] ctr_inc;
    shape_n    = shape_q;
    period_n   = period_q;
    ctr_n      = ctr_q;
    step_n     = step_q;
    hold_val_n = hold_val_q;
    dir_n      = dir_q;
    held_n     = held_q;
    out_n      = '0;
    sel_shape  = 1'b0;
    sel_period = 1'b0;
    eff        = '0;
    ctr_inc    = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      sel_shape  = wr_bus.wr_en && wr_bus.wr_is_shape && (int'(wr_bus.wr_ch) == c);
      sel_period = wr_bus.wr_en && !wr_bus.wr_is_shape && (int'(wr_bus.wr_ch) == c);
      eff        = (period_q[c] == '0) ? {{PERIOD_W{1'b0}}, 1'b1} : {1'b0, period_q[c]};
      ctr_inc    = {1'b0, ctr_q[c]} + 1'b1;

      if (sel_shape) begin
        shape_n[c] = wr_bus.wr_data[3:0];
        step_n[c]  = '0;
        ctr_n[c]   = '0;
        dir_n[c]   = wr_bus.wr_data[2];
        held_n[c]  = 1'b0;
      end else if (env_clk_tick && !held_q[c]) begin
        if (ctr_inc >= eff) begin
          ctr_n[c] = '0;
          if (step_q[c] != MAX) begin
            step_n[c] = step_q[c] + 1'b1;
          end else if (!shape_q[c][3]) begin
            held_n[c]     = 1'b1;
            hold_val_n[c] = '0;
          end else if (shape_q[c][0]) begin
            held_n[c]     = 1'b1;
            hold_val_n[c] = (shape_q[c][2] ^ shape_q[c][1]) ? MAX : '0;
          end else begin
            if (shape_q[c][1]) dir_n[c] = ~dir_q[c];
            step_n[c] = '0;
          end
        end else begin
          ctr_n[c] = ctr_inc[PERIOD_W-1:0];
        end
      end

      if (sel_period) period_n[c] = wr_bus.wr_data;

      out_n[c*AMP_W +: AMP_W] = held_n[c] ? hold_val_n[c]
                              : (dir_n[c] ? step_n[c] : ~step_n[c]);
    end
  end

  // State and output registers, synchronous active-high reset
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int c = 0; c < NUM_CH; c++) begin
        shape_q[c]    <= '0;
        period_q[c]   <= '0;
        ctr_q[c]      <= '0;
        step_q[c]     <= '0;
        hold_val_q[c] <= '0;
      end
      dir_q  <= '0;
      held_q <= '1;
      out    <= '0;
    end else begin
      shape_q    <= shape_n;
      period_q   <= period_n;
      ctr_q      <= ctr_n;
      step_q     <= step_n;
      hold_val_q <= hold_val_n;
      dir_q      <= dir_n;
      held_q     <= held_n;
      out        <= out_n;
    end
  end

`ifdef AY_ENV_DONE_EN
  // Pulse once on the held 0->1 edge. A restart clears held, so no pulse.
  always_ff @(posedge clk) begin
    if (reset) env_done <= '0;
    else       env_done <= held_n & ~held_q;
  end
`endif

endmodule

// File: tb/tb_ay_env_multi.sv
// Self-checking bench for ay_env_multi: a vector table, hand-written corner
// sequences and a randomized run against a behavioural envelope model.
module tb_ay_env_multi;

  logic        clk;
  logic        reset;
  logic        tick;
  logic        tick5;
  logic [11:0] out;
  logic [14:0] out5;
`ifdef AY_ENV_DONE_EN
  logic [2:0]  env_done;
  logic [2:0]  done5;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  ay_env_multi_if #(.NUM_CH(3), .PERIOD_W(16)) bus4 ();
  ay_env_multi_if #(.NUM_CH(3), .PERIOD_W(16)) bus5 ();

  ay_env_multi #(.NUM_CH(3), .AMP_W(4), .PERIOD_W(16)) dut (
    .clk(clk), .reset(reset), .env_clk_tick(tick), .wr_bus(bus4), .out(out)
`ifdef AY_ENV_DONE_EN
    , .env_done(env_done)
`endif
  );

  ay_env_multi #(.NUM_CH(3), .AMP_W(5), .PERIOD_W(16)) dut5 (
    .clk(clk), .reset(reset), .env_clk_tick(tick5), .wr_bus(bus5), .out(out5)
`ifdef AY_ENV_DONE_EN
    , .env_done(done5)
`endif
  );

  // Clock / reset defaults
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: per channel, k = number of step advances since the
  // last shape write; amplitude is a closed-form function of shape and k.
  int         m_period [3];
  int         m_ctr    [3];
  int         m_k      [3];
  logic [3:0] m_shape  [3];
  bit         m_written[3];
  bit         m_done   [3];

  function automatic int env_val(input logic [3:0] shape, input int k, input int w);
    int m, mx, r, s;
    bit d;
    m  = 1 << w;
    mx = m - 1;
    if (k < m) return shape[2] ? k : mx - k;
    if (!shape[3]) return 0;
    if (shape[0]) return (shape[2] ^ shape[1]) ? mx : 0;
    r = k / m;
    s = k % m;
    d = shape[1] ? (shape[2] ^ bit'(r % 2)) : shape[2];
    return d ? s : mx - s;
  endfunction

  function automatic bit is_held(input logic [3:0] shape, input int k, input int w);
    return (k >= (1 << w)) && (!shape[3] || shape[0]);
  endfunction

  function automatic logic [11:0] model_out();
    logic [11:0] v;
    v = '0;
    for (int c = 0; c < 3; c++)
      if (m_written[c]) v[c*4 +: 4] = 4'(env_val(m_shape[c], m_k[c], 4));
    return v;
  endfunction

  function automatic logic [2:0] model_done();
    logic [2:0] v;
    for (int c = 0; c < 3; c++) v[c] = m_done[c];
    return v;
  endfunction

  function automatic void model_step(input bit rst, input bit tk, input bit we,
                                     input logic [1:0] ch, input bit sh,
                                     input logic [15:0] d);
    int eff;
    bit hit;
    for (int c = 0; c < 3; c++) begin
      m_done[c] = 1'b0;
      if (rst) begin
        m_period[c] = 0; m_ctr[c] = 0; m_k[c] = 0;
        m_shape[c] = '0; m_written[c] = 1'b0;
      end else begin
        hit = we && (int'(ch) == c);
        if (hit && sh) begin
          m_shape[c] = d[3:0]; m_k[c] = 0; m_ctr[c] = 0; m_written[c] = 1'b1;
        end else if (tk && m_written[c] && !is_held(m_shape[c], m_k[c], 4)) begin
          eff = (m_period[c] == 0) ? 1 : m_period[c];
          if (m_ctr[c] + 1 >= eff) begin
            m_ctr[c] = 0;
            m_k[c]++;
            if (is_held(m_shape[c], m_k[c], 4)) m_done[c] = 1'b1;
          end else begin
            m_ctr[c]++;
          end
        end
        if (hit && !sh) m_period[c] = int'(d);
      end
    end
  endfunction

  // Driver tasks: apply on negedge, sample 1 time unit after posedge
  task automatic cyc(input bit rst, input bit tk, input bit we,
                     input logic [1:0] ch, input bit sh, input logic [15:0] d);
    @(negedge clk);
    reset = rst; tick = tk;
    bus4.wr_en = we; bus4.wr_ch = ch; bus4.wr_is_shape = sh; bus4.wr_data = d;
    tick5 = 1'b0; bus5.wr_en = 1'b0;
    @(posedge clk);
    #1;
    model_step(rst, tk, we, ch, sh, d);
  endtask

  task automatic cyc5(input bit tk, input bit we, input logic [1:0] ch,
                      input bit sh, input logic [15:0] d);
    @(negedge clk);
    reset = 1'b0; tick = 1'b0; bus4.wr_en = 1'b0;
    tick5 = tk;
    bus5.wr_en = we; bus5.wr_ch = ch; bus5.wr_is_shape = sh; bus5.wr_data = d;
    @(posedge clk);
    #1;
  endtask

  // Scoreboard check
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    bit          tk;
    bit          we;
    logic [1:0]  ch;
    bit          sh;
    logic [15:0] d;
    logic [11:0] exp;
  } vec_t;

  vec_t vecs[10];
  logic [11:0] exp_q[$];

  initial begin
    int k, r, s, e;
    bit rr, tk, we, sh;
    logic [1:0] ch;
    logic [15:0] d;

    reset = 1'b0; tick = 1'b0; tick5 = 1'b0;
    bus4.wr_en = 1'b0; bus4.wr_ch = '0; bus4.wr_is_shape = 1'b0; bus4.wr_data = '0;
    bus5.wr_en = 1'b0; bus5.wr_ch = '0; bus5.wr_is_shape = 1'b0; bus5.wr_data = '0;

    vecs[0] = '{1'b1, 1'b1, 2'd0, 1'b0, 16'd1,   12'h000};
    vecs[1] = '{1'b0, 1'b1, 2'd0, 1'b1, 16'h000C, 12'h000};
    vecs[2] = '{1'b1, 1'b0, 2'd0, 1'b0, 16'd0,   12'h001};
    vecs[3] = '{1'b1, 1'b0, 2'd0, 1'b0, 16'd0,   12'h002};
    vecs[4] = '{1'b1, 1'b1, 2'd1, 1'b1, 16'h0000, 12'h0F3};
    vecs[5] = '{1'b1, 1'b0, 2'd0, 1'b0, 16'd0,   12'h0E4};
    vecs[6] = '{1'b0, 1'b1, 2'd3, 1'b1, 16'h0004, 12'h0E4};
    vecs[7] = '{1'b1, 1'b1, 2'd1, 1'b0, 16'd2,   12'h0D5};
    vecs[8] = '{1'b1, 1'b0, 2'd0, 1'b0, 16'd0,   12'h0D6};
    vecs[9] = '{1'b1, 1'b0, 2'd0, 1'b0, 16'd0,   12'h0C7};

    // Reset, then idle ticks
    cyc(1, 0, 0, 0, 0, 0);
    check("reset_out", 32'(out), 0);
    check("reset_out5", 32'(out5), 0);
    for (int i = 0; i < 20; i++) begin
      cyc(0, 1, 0, 0, 0, 0);
      check("idle_out", 32'(out), 0);
`ifdef AY_ENV_DONE_EN
      check("idle_done", 32'(env_done), 0);
`endif
    end

    // Vector table
    cyc(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      cyc(0, vecs[i].tk, vecs[i].we, vecs[i].ch, vecs[i].sh, vecs[i].d);
      check($sformatf("vec%0d", i), 32'(out), 32'(vecs[i].exp));
    end

    // Sawtooth ch0, period 1, shape 0xC
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 16'd1);
    cyc(0, 0, 1, 0, 1, 16'h000C);
    check("saw_start", 32'(out), 0);
    for (int n = 1; n <= 40; n++) begin
      cyc(0, 1, 0, 0, 0, 0);
      check("saw_out0", 32'(out[3:0]), 32'(n % 16));
      check("saw_others", 32'(out[11:4]), 0);
    end

    // Triangle ch1, period 2, shape 0xE, then reset mid-ramp
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 1, 0, 16'd2);
    cyc(0, 0, 1, 1, 1, 16'h000E);
    for (int n = 1; n <= 130; n++) begin
      cyc(0, 1, 0, 0, 0, 0);
      k = n / 2; r = k / 16; s = k % 16;
      check("tri_out1", 32'(out[7:4]), 32'((r % 2 == 0) ? s : 15 - s));
    end
    cyc(1, 1, 0, 0, 0, 0);
    check("midramp_reset", 32'(out), 0);

    // Shape 0x0 on ch2 and 0x4 on ch0, period 3
    cyc(0, 0, 1, 2, 0, 16'd3);
    cyc(0, 0, 1, 0, 0, 16'd3);
    cyc(0, 0, 1, 2, 1, 16'h0000);
    cyc(0, 0, 1, 0, 1, 16'h0004);
    check("decay_start", 32'(out), 32'h F00);
    for (int n = 1; n <= 60; n++) begin
      cyc(0, 1, 0, 0, 0, 0);
      k = n / 3;
      check("decay_out2", 32'(out[11:8]), 32'((k < 16) ? 15 - k : 0));
      check("attack_out0", 32'(out[3:0]), 32'((k < 16) ? k : 0));
`ifdef AY_ENV_DONE_EN
      check("decay_done", 32'(env_done), (n == 48) ? 32'h5 : 32'h0);
`endif
    end

    // AMP_W=5 instance: ch2 period 0, shape 0xB
    cyc(1, 0, 0, 0, 0, 0);
    cyc5(0, 1, 2, 0, 16'd0);
    cyc5(0, 1, 2, 1, 16'h000B);
    check("y5_start", 32'(out5[14:10]), 31);
    for (int n = 1; n <= 40; n++) begin
      cyc5(1, 0, 0, 0, 0);
      check("y5_out2", 32'(out5[14:10]), 32'((n < 32) ? 31 - n : 31));
      check("y5_others", 32'(out5[9:0]), 0);
`ifdef AY_ENV_DONE_EN
      check("y5_done", 32'(done5), (n == 32) ? 32'h4 : 32'h0);
`endif
    end

    // Shape write colliding with the ctr-expiry tick at step 7
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 16'd2);
    cyc(0, 0, 1, 0, 1, 16'h000C);
    for (int n = 1; n <= 15; n++) cyc(0, 1, 0, 0, 0, 0);
    check("coll_pre", 32'(out[3:0]), 7);
    cyc(0, 1, 1, 0, 1, 16'h0008);
    check("coll_write", 32'(out[3:0]), 15);
    cyc(0, 1, 0, 0, 0, 0);
    check("coll_ctr0", 32'(out[3:0]), 15);
    cyc(0, 1, 0, 0, 0, 0);
    check("coll_next", 32'(out[3:0]), 14);

    // Period write landing on an expiry tick uses the old period
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 16'd2);
    cyc(0, 0, 1, 0, 1, 16'h000C);
    cyc(0, 1, 0, 0, 0, 0);
    check("pw_pre", 32'(out[3:0]), 0);
    cyc(0, 1, 1, 0, 0, 16'd5);
    check("pw_oldper", 32'(out[3:0]), 1);
    for (int n = 1; n <= 4; n++) begin
      cyc(0, 1, 0, 0, 0, 0);
      check("pw_newper_hold", 32'(out[3:0]), 1);
    end
    cyc(0, 1, 0, 0, 0, 0);
    check("pw_newper_adv", 32'(out[3:0]), 2);

    // Randomized run against the model
    cyc(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      rr = ($urandom_range(0, 299) == 0);
      tk = bit'($urandom_range(0, 1));
      we = ($urandom_range(0, 3) == 0);
      ch = 2'($urandom_range(0, 3));
      sh = bit'($urandom_range(0, 1));
      d  = sh ? 16'($urandom_range(0, 65535)) : 16'($urandom_range(0, 5));
      cyc(rr, tk, we, ch, sh, d);
      exp_q.push_back(model_out());
      check("rand_out", 32'(out), 32'(exp_q.pop_front()));
`ifdef AY_ENV_DONE_EN
      check("rand_done", 32'(env_done), 32'(model_done()));
`endif
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ay_env_multi.md
Name: ay_env_multi

Overview:
- Parametrised multi-channel envelope generator for the AY/YM sound core.
- Holds NUM_CH independent envelopes, each with its own shape and period register, written through a simple write port.
- Implements all 16 AY shapes with a configurable amplitude width (AMP_W=4 for AY, 5 for YM-style 32-step).
- Sits between the register file and the per-channel volume mixers.

Parameters:
- NUM_CH, 3, number of independent envelope channels (1..8).
- AMP_W, 4, amplitude width; 2^AMP_W steps per ramp.
- PERIOD_W, 16, period register width.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- env_clk_tick  in  1  one-cycle prescaler tick, shared by all channels
- wr_en  in  1  write strobe
- wr_ch  in  $clog2(NUM_CH) (min 1)  target channel
- wr_is_shape  in  1  1 = write shape (wr_data[3:0]); 0 = write period (wr_data)
- wr_data  in  PERIOD_W  write data
- out  out  NUM_CH*AMP_W  channel c amplitude at [c*AMP_W +: AMP_W]

Behaviour:
- Shape bits: shape[3]=cont, shape[2]=attack, shape[1]=alt, shape[0]=hold. MAX = 2^AMP_W-1.
- Per-channel state: period_reg, ctr (PERIOD_W), step (AMP_W), dir (1 = rising), held, hold_val.
- Reset: all shape/period registers 0, ctr=0, step=0, held=1, hold_val=0. Every out field is 0.
- Output: out_c = held ? hold_val : (dir ? step : ~step).
  - out is registered and computed from next-state, so it changes on the same edge as the state it reflects.
  - Latency from a tick or write input to out is 1 cycle.
- Period write: updates period_reg only. No restart; ctr is kept.
- Shape write (restart), on a channel's next edge:
  - step=0, ctr=0, dir=attack, held=0.
  - out becomes MAX if attack=0, or 0 if attack=1.
- Tick on a non-held channel:
  - eff_period = (period_reg==0) ? 1 : period_reg.
  - If ctr+1 >= eff_period: ctr=0 and the step advances. Otherwise ctr=ctr+1.
  - ctr width is PERIOD_W+1 internally for the compare, so there is no wrap.
- Step advance, when step < MAX: step=step+1.
- Step advance, when step == MAX (end of ramp):
  - cont=0: held=1, hold_val=0.
  - cont=1, hold=1: held=1, hold_val = (attack^alt) ? MAX : 0.
  - cont=1, hold=0, alt=1: dir=~dir, step=0. Triangle peaks repeat one value, matching AY.
  - cont=1, hold=0, alt=0: step=0 (sawtooth).
- Held channels ignore ticks; ctr is frozen.
- Simultaneous shape write and tick on the same channel: the write wins and the tick is discarded for that channel. Other channels process the tick normally.
- Simultaneous period write and tick on the same channel: this cycle compares against the old period_reg; the new value is used from the next tick.
- wr_ch >= NUM_CH: write ignored.
- Reset mid-ramp returns the channel to the reset state on the next edge.

Optional Feature:
- Macro: AY_ENV_DONE_EN.
- Defined:
  - Adds output port env_done, width NUM_CH.
  - Bit c pulses high for exactly one cycle on the edge where channel c transitions held 0->1.
  - No pulse at reset, and none for a write that is immediately overridden.
- Undefined: no port and no logic. All other behaviour is identical.

Test Plan:
- Reset, then 20 ticks with no writes -> all out fields 0 and remain 0; env_done never asserts.
- AMP_W=4, ch0 period=1, shape=0xC, tick every cycle:
  - out0 = 0,1,…,15,0,1,… (sawtooth, 16-tick period).
  - ch1 and ch2 stay 0.
- AMP_W=4, ch1 period=2, shape=0xE, tick every cycle:
  - out1 rises 0..15, then falls 15..0, then rises again.
  - Each value lasts 2 ticks; 64 ticks per full triangle.
- AMP_W=5, ch2 period=0 (treated as 1), shape=0xB:
  - out2 starts at 31, decays to 0 over 32 ticks, then jumps to 31 and holds.
  - env_done[2] pulses once on the hold edge.
- Shape 0x0 (and separately 0x4), period=3:
  - 0x0: out falls 15→0 over 48 ticks, then holds 0.
  - 0x4: out rises 0→15, then drops to 0 and holds.
  - Further ticks change nothing.
- Collision: ch0 mid-ramp (step=7), a shape=0x8 write coincides with the ctr-expiry tick -> next edge out0=15, ctr=0, and the tick has no effect. A separate period write landing on an expiry tick uses the old period for that compare.
